// File: rtl/dmac_multi.sv
// Multi-channel DMA controller: fixed-priority grant, cycle-steal or burst transfers.
// Define DMAC_AUTOINIT_EN to enable base-register reload (auto-initialisation) at end of process.
module dmac_multi #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int DW  = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] DREQ,
    output logic [NCH-1:0] DACK,
    output logic           HLD,
    input  logic           HLDA,
    input  logic           RDY,
    input  logic           REGW,
    input  logic [1:0]     REGSEL,
    input  logic [1:0]     CHSEL,
    input  logic [AW-1:0]  Setup,
    input  logic [DW-1:0]  Data_in,
    output logic [DW-1:0]  Data_out,
    output logic           MEMR,
    output logic           MEMW,
    output logic           IOR,
    output logic           IOW,
    output logic [AW-1:0]  Addrbus,
    output logic           EOP,
    output logic [1:0]     ACTCH
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]    state;
    logic [3:0]    mode  [NCH];
    logic [AW-1:0] count [NCH];
    logic [AW-1:0] addr  [NCH];
`ifdef DMAC_AUTOINIT_EN
    logic [AW-1:0] base_count [NCH];
    logic [AW-1:0] base_addr  [NCH];
`endif
    logic [DW-1:0] data_q;
    logic          eop_q;
    logic          grant_ok;
    logic [1:0]    grant_ch;
    logic          wr_ok;

    always_comb begin
        grant_ok = 1'b0;
        grant_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_ok && mode[i][0] && DREQ[i] && count[i] != '0) begin
                grant_ok = 1'b1;
                grant_ch = 2'(i);
            end
        end
    end

    // The active channel's registers are frozen while a transfer is in flight.
    assign wr_ok = REGW && (int'(CHSEL) < NCH) && !(state != S_IDLE && CHSEL == ACTCH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            ACTCH  <= '0;
            data_q <= '0;
            eop_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                mode[i]  <= '0;
                count[i] <= '0;
                addr[i]  <= '0;
`ifdef DMAC_AUTOINIT_EN
                base_count[i] <= '0;
                base_addr[i]  <= '0;
`endif
            end
        end else begin
            eop_q <= 1'b0;
            if (wr_ok) begin
                case (REGSEL)
`ifdef DMAC_AUTOINIT_EN
                    2'b00: mode[CHSEL] <= Setup[3:0];
                    2'b01: begin count[CHSEL] <= Setup; base_count[CHSEL] <= Setup; end
                    2'b10: begin addr[CHSEL]  <= Setup; base_addr[CHSEL]  <= Setup; end
`else
                    2'b00: mode[CHSEL] <= {1'b0, Setup[2:0]};
                    2'b01: count[CHSEL] <= Setup;
                    2'b10: addr[CHSEL]  <= Setup;
`endif
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: if (!REGW && grant_ok) begin
                    ACTCH <= grant_ch;
                    state <= S_REQ;
                end
                S_REQ: if (HLDA) state <= S_READ;
                S_READ: begin
                    if (!HLDA) begin
                        state <= S_REQ;
                    end else if (RDY) begin
                        data_q <= Data_in;
                        state  <= S_WRITE;
                    end
                end
                default: if (RDY) begin
                    addr[ACTCH]  <= addr[ACTCH] + AW'(1);
                    count[ACTCH] <= count[ACTCH] - AW'(1);
                    if (count[ACTCH] == AW'(1)) begin
                        eop_q <= 1'b1;
                        state <= S_IDLE;
`ifdef DMAC_AUTOINIT_EN
                        if (mode[ACTCH][3]) begin
                            count[ACTCH] <= base_count[ACTCH];
                            addr[ACTCH]  <= base_addr[ACTCH];
                        end else begin
                            mode[ACTCH][0] <= 1'b0;
                        end
`else
                        mode[ACTCH][0] <= 1'b0;
`endif
                    end else if (mode[ACTCH][2] && DREQ[ACTCH] && HLDA) begin
                        state <= S_READ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // EOP is registered, so it is seen in the IDLE cycle that follows the last WRITE.
    always_comb begin
        HLD      = (state != S_IDLE);
        EOP      = eop_q;
        DACK     = '0;
        MEMR     = 1'b0;
        MEMW     = 1'b0;
        IOR      = 1'b0;
        IOW      = 1'b0;
        Addrbus  = '0;
        Data_out = '0;
        if (state == S_READ) begin
            DACK    = NCH'(1) << ACTCH;
            MEMR    = !mode[ACTCH][1];
            IOR     = mode[ACTCH][1];
            Addrbus = addr[ACTCH];
        end else if (state == S_WRITE) begin
            DACK     = NCH'(1) << ACTCH;
            IOW      = !mode[ACTCH][1];
            MEMW     = mode[ACTCH][1];
            Addrbus  = addr[ACTCH];
            Data_out = data_q;
        end
    end

endmodule

// File: doc/dmac_multi.md
DMAC_MULTI -- requirements
Module: dmac_multi

Interface
REQ-001 Parameter NCH, default 4, number of channels (legal 1..4).
REQ-002 Parameter AW, default 16, address and count width (legal 8..32).
REQ-003 Parameter DW, default 8, data width.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 DREQ  in  NCH  per-channel transfer request, level-sensitive.
REQ-007 DACK  out  NCH  one-hot acknowledge to the granted channel.
REQ-008 HLD  out  1  bus request to CPU; HLDA  in  1  bus grant from CPU.
REQ-009 RDY  in  1  slave ready; low inserts wait states.
REQ-010 REGW  in  1  register write strobe; REGSEL  in  2  register select (00 mode, 01 count, 10 address, 11 ignored).
REQ-011 CHSEL  in  2  target channel of a register write; values >= NCH are ignored.
REQ-012 Setup  in  AW  register write data.
REQ-013 Data_in  in  DW  read data; Data_out  out  DW  write data.
REQ-014 MEMR, MEMW, IOR, IOW  out  1 each  bus strobes; Addrbus  out  AW  memory address.
REQ-015 EOP  out  1  one-cycle end-of-process pulse; ACTCH  out  2  index of the granted channel.

Function
REQ-016 Mode register: bit0 EN; bit1 DIR (0 mem->IO, 1 IO->mem); bit2 BURST (0 cycle-steal, 1 burst); bit3 AUTO; other bits are stored as zero.
REQ-017 Count is the number of transfers; a channel with count 0 is never granted.
REQ-018 States are IDLE, REQ, READ and WRITE.
REQ-019 In IDLE with REGW=0, the lowest-index channel with EN=1, DREQ=1 and count!=0 is granted: ACTCH is latched, HLD=1, and the state goes to REQ.
REQ-020 In IDLE with REGW=1, no grant is made that cycle.
REQ-021 REQ: HLD held; HLDA=1 -> READ next cycle; otherwise stay in REQ.
REQ-022 READ: DACK[ch]=1; MEMR=1 (DIR=0) or IOR=1 (DIR=1); Addrbus=address[ch].
REQ-023 READ with RDY=1 latches Data_in and goes to WRITE.
REQ-024 READ with RDY=0 stays in READ.
REQ-025 READ with HLDA=0 returns to REQ with no register change; this check takes priority over RDY.
REQ-026 WRITE: DACK[ch]=1; IOW=1 (DIR=0) or MEMW=1 (DIR=1); Data_out=latched data; Addrbus=address[ch]; RDY=0 stays in WRITE; HLDA is ignored.
REQ-027 WRITE completion (RDY=1): address+1 modulo 2^AW (0xFFFF wraps to 0x0000 at AW=16), count-1.
REQ-028 When count reaches 0: EOP=1 for exactly the next cycle, EN is cleared (REQ-041 aside), and the state goes to IDLE.
REQ-029 Count nonzero, cycle-steal: go to IDLE; HLD stays low for at least one cycle before re-request.
REQ-030 Count nonzero, burst, DREQ[ch]=1 and HLDA=1: go to READ directly with HLD held; otherwise go to IDLE.
REQ-031 At most one strobe is asserted in any cycle; outside READ and WRITE, strobes, DACK and EOP are 0.
REQ-032 Outside READ and WRITE, Addrbus and Data_out are 0.
REQ-033 A REGW to the granted channel while the state is not IDLE is ignored; writes to other channels take effect.
REQ-034 DREQ[ch] dropping mid-transfer does not abort the transfer; it only ends a burst at REQ-030.

Reset
REQ-035 RST=1 at a clock edge: state IDLE; all mode, count and address registers 0; data latch 0.
REQ-036 RST=1 at a clock edge: HLD, DACK, strobes, EOP, Addrbus, Data_out and ACTCH are 0 the following cycle.
REQ-037 Reset asserted mid-transfer aborts the transfer without an EOP or a register update.

Configuration
REQ-038 Macro DMAC_AUTOINIT_EN controls auto-initialisation.
REQ-039 With DMAC_AUTOINIT_EN defined, writes to count or address also load per-channel base-count and base-address shadow registers.
REQ-040 With DMAC_AUTOINIT_EN defined, the shadow registers are reset to 0.
REQ-041 With DMAC_AUTOINIT_EN defined and AUTO=1, EOP reloads count and address from the shadows and EN stays 1.
REQ-042 Without DMAC_AUTOINIT_EN, mode bit3 is stored as 0, no shadow registers exist, and EOP always clears EN.

Verification
REQ-043 Ch0 mode 0x01, count 3, addr 0x0001, DREQ0=1, HLDA=1, RDY=1 -> three READ/WRITE pairs at Addrbus 0x0001/0x0002/0x0003 with MEMR then IOW; HLD low between pairs; EOP after the third WRITE.
REQ-044 Ch1 mode 0x07, count 2, addr 0x0010, IO->mem burst -> IOR/MEMW pairs at 0x0010 and 0x0011 back-to-back with HLD continuously high, then EOP.
REQ-045 Ch0 and ch2 enabled with DREQ raised the same cycle -> ch0 is fully served (ACTCH=0) before ch2 is granted.
REQ-046 RDY=0 for 3 cycles in READ -> READ lasts 4 cycles; HLDA dropped in READ -> back to REQ, count unchanged; RST pulsed in WRITE -> all outputs 0 with no EOP.
REQ-047 Addr 0xFFFF, count 2 -> second transfer at Addrbus 0x0000.
REQ-048 With DMAC_AUTOINIT_EN and mode 0x09, count 2 -> after EOP, count is 2, address is back to base and the channel is re-granted; without the macro, the channel goes idle.
